// File: rtl/la_bridge_pkg.sv
// Shared types and la_data_in field offsets for the logic-analyzer capture bridge.
package la_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } la_cap_state_e;

  localparam int TRIG_LSB = 0;
  localparam int ARM_BIT  = 32;
  localparam int RD_BIT   = 33;
  localparam int MODE_LSB = 34;
  localparam int CLR_BIT  = 64;

  localparam logic [1:0] MODE_ALWAYS = 2'd0;
  localparam logic [1:0] MODE_EQ     = 2'd1;
  localparam logic [1:0] MODE_NE     = 2'd2;
  localparam logic [1:0] MODE_ALT    = 2'd3;

endpackage

// File: rtl/la_capture_fifo.sv
// Linear capture buffer: fills from entry 0, drains first-word fall-through, never wraps.
module la_capture_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  input  logic                     clr,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_pop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign do_wr  = wr && !full && !clr;
  assign do_pop = pop && !empty && !clr;

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/la_capture_bridge.sv
// Triggered capture buffer exposed over the management SoC logic-analyzer bus.
module la_capture_bridge
  import la_bridge_pkg::*;
#(
  parameter int PROBE_W  = 32,
  parameter int DEPTH    = 16,
  parameter int LA_IN_W  = 65,
  parameter int LA_OUT_W = 111
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [PROBE_W-1:0]  probe_i,
  input  logic [LA_IN_W-1:0]  la_data_in,
  output logic [LA_OUT_W-1:0] la_data_out
);
  localparam int CW = $clog2(DEPTH) + 1;

  la_cap_state_e      state;
  logic               arm_prev;
  logic               rd_prev;
  logic               underflow;
  logic               arm;
  logic               rd;
  logic               clr;
  logic [1:0]         mode;
  logic [PROBE_W-1:0] trig_val;
  logic               arm_rise;
  logic               rd_rise;
  logic               hit;
  logic               fifo_wr;
  logic               fifo_pop;
  logic               fifo_clr;
  logic [PROBE_W-1:0] rd_data;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;
  logic               unused_la_bits;

  assign arm      = la_data_in[ARM_BIT];
  assign rd       = la_data_in[RD_BIT];
  assign clr      = la_data_in[CLR_BIT];
  assign mode     = la_data_in[MODE_LSB +: 2];
  assign trig_val = la_data_in[TRIG_LSB +: PROBE_W];
  assign unused_la_bits = ^la_data_in;

  // Previous-value registers reset high so a level held through reset is not an edge.
  assign arm_rise = arm && !arm_prev;
  assign rd_rise  = rd && !rd_prev;

  always_comb begin
    case (mode)
      MODE_EQ: hit = (probe_i == trig_val);
      MODE_NE: hit = (probe_i != trig_val);
      default: hit = 1'b1;
    endcase
  end

  assign fifo_clr = clr || arm_rise;
  assign fifo_wr  = !fifo_clr &&
                    (((state == ST_ARMED) && hit) || (state == ST_CAPTURE));
  assign fifo_pop = !fifo_clr && (state == ST_DONE) && rd_rise;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= ST_IDLE;
      arm_prev  <= 1'b1;
      rd_prev   <= 1'b1;
      underflow <= 1'b0;
    end else begin
      arm_prev <= arm;
      rd_prev  <= rd;
      if (clr) begin
        state     <= ST_IDLE;
        underflow <= 1'b0;
      end else if (arm_rise) begin
        state     <= ST_ARMED;
        underflow <= 1'b0;
      end else begin
        case (state)
          ST_ARMED:   if (hit) state <= ST_CAPTURE;
          ST_CAPTURE: if (count == CW'(DEPTH - 1)) state <= ST_DONE;
          ST_DONE:    if (rd_rise && empty) underflow <= 1'b1;
          default:    state <= state;
        endcase
      end
    end
  end

  la_capture_fifo #(
    .W     (PROBE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .wr      (fifo_wr),
    .wdata   (probe_i),
    .pop     (fifo_pop),
    .clr     (fifo_clr),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    la_data_out = '0;
    la_data_out[PROBE_W-1:0]          = rd_data;
    la_data_out[PROBE_W +: CW]        = count;
    la_data_out[PROBE_W + CW +: 2]    = state;
    la_data_out[PROBE_W + CW + 2]     = full;
    la_data_out[PROBE_W + CW + 3]     = empty;
    la_data_out[PROBE_W + CW + 4]     = underflow;
  end

endmodule

// File: tb/tb_la_capture_bridge.sv
// Scoreboard bench for la_capture_bridge at default parameters (32-bit probe, depth 16).
module tb_la_capture_bridge;
  localparam int PROBE_W  = 32;
  localparam int DEPTH    = 16;
  localparam int LA_IN_W  = 65;
  localparam int LA_OUT_W = 111;

  logic                clk;
  logic                rst_n;
  logic [PROBE_W-1:0]  probe;
  logic [LA_IN_W-1:0]  la_in;
  logic [LA_OUT_W-1:0] la_out;

  logic [31:0] trig;
  logic        arm;
  logic        rd;
  logic [1:0]  mode;
  logic        clr;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic        m_armed;
  logic        m_cap;
  int          m_n;
  logic [31:0] last_rd;

  la_capture_bridge #(
    .PROBE_W  (PROBE_W),
    .DEPTH    (DEPTH),
    .LA_IN_W  (LA_IN_W),
    .LA_OUT_W (LA_OUT_W)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .probe_i     (probe),
    .la_data_in  (la_in),
    .la_data_out (la_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ignored control bits are driven high to show they have no effect.
  always_comb begin
    la_in        = '0;
    la_in[63:40] = '1;
    la_in[31:0]  = trig;
    la_in[32]    = arm;
    la_in[33]    = rd;
    la_in[35:34] = mode;
    la_in[64]    = clr;
  end

  function automatic logic [31:0] f_rd();   return la_out[31:0];  endfunction
  function automatic logic [4:0]  f_cnt();  return la_out[36:32]; endfunction
  function automatic logic [1:0]  f_st();   return la_out[38:37]; endfunction
  function automatic logic        f_full(); return la_out[39];    endfunction
  function automatic logic        f_emp();  return la_out[40];    endfunction
  function automatic logic        f_uf();   return la_out[41];    endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_hit(input logic [31:0] p);
    case (mode)
      2'd1:    return p == trig;
      2'd2:    return p != trig;
      default: return 1'b1;
    endcase
  endfunction

  task automatic do_arm();
    arm     = 1'b1;
    m_armed = 1'b1;
    m_cap   = 1'b0;
    m_n     = 0;
    exp_q.delete();
    tick();
    arm = 1'b0;
  endtask

  task automatic step_probe(input logic [31:0] p);
    probe = p;
    if (m_armed && !m_cap && model_hit(p)) m_cap = 1'b1;
    if (m_cap && m_n < DEPTH) begin
      exp_q.push_back(p);
      m_n++;
    end
    tick();
  endtask

  task automatic read_all(input string tag);
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, f_rd(), e);
      last_rd = f_rd();
      rd = 1'b1;
      tick();
      rd = 1'b0;
      check({tag, "_cnt"}, f_cnt(), exp_q.size());
      tick();
    end
  endtask

  localparam logic [LA_OUT_W-1:0] RESET_OUT = LA_OUT_W'(1) << 40;

  initial begin
    rst_n = 1'b0; arm = 1'b1; rd = 1'b0; mode = 2'd0; clr = 1'b0;
    trig = '0; probe = '0; m_armed = 1'b0; m_cap = 1'b0; m_n = 0; last_rd = '0;

    // Reset released with arm already high
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) tick();
    check("rst_out", la_out, RESET_OUT);
    arm = 1'b0;
    tick();
    check("rst_idle", f_st(), 2'd0);

    // Mode 0, incrementing probe
    mode = 2'd0;
    do_arm();
    check("m0_armed", f_st(), 2'd1);
    for (int i = 0; i < DEPTH; i++) step_probe(32'(i));
    check("m0_state", f_st(), 2'd3);
    check("m0_cnt", f_cnt(), 5'd16);
    check("m0_full", f_full(), 1'b1);
    step_probe(32'h99);
    check("m0_nowrap", f_cnt(), 5'd16);
    read_all("m0");
    check("m0_empty", f_emp(), 1'b1);
    check("m0_uf_pre", f_uf(), 1'b0);
    rd = 1'b1; tick(); rd = 1'b0; tick();
    check("m0_uf", f_uf(), 1'b1);
    check("m0_rd0", f_rd(), 32'd0);
    check("m0_cnt0", f_cnt(), 5'd0);

    // Mode 1, equality trigger on a sweep
    mode = 2'd1; trig = 32'hA5;
    do_arm();
    check("m1_uf_clr", f_uf(), 1'b0);
    for (int i = 0; i < 256; i++) step_probe(32'(i));
    check("m1_state", f_st(), 2'd3);
    check("m1_first", f_rd(), 32'hA5);
    read_all("m1");
    check("m1_last", last_rd, 32'hB4);

    // Mode 2, inequality trigger
    mode = 2'd2; trig = 32'd7;
    do_arm();
    for (int i = 0; i < 20; i++) begin
      step_probe(32'd7);
      check("m2_armed", f_st(), 2'd1);
    end
    for (int i = 0; i < DEPTH; i++) step_probe(32'd9);
    check("m2_state", f_st(), 2'd3);
    check("m2_first", f_rd(), 32'd9);
    read_all("m2");

    // Re-arm mid-capture, then clr in DONE
    mode = 2'd0;
    do_arm();
    for (int i = 0; i < 5; i++) step_probe(32'(50 + i));
    check("ra_cnt5", f_cnt(), 5'd5);
    check("ra_cap", f_st(), 2'd2);
    do_arm();
    check("ra_cnt0", f_cnt(), 5'd0);
    check("ra_armed", f_st(), 2'd1);
    for (int i = 0; i < DEPTH; i++) step_probe(32'(100 + i));
    check("ra_cnt16", f_cnt(), 5'd16);
    check("ra_first", f_rd(), 32'd100);
    clr = 1'b1;
    tick();
    check("clr_state", f_st(), 2'd0);
    check("clr_cnt", f_cnt(), 5'd0);
    check("clr_out", la_out, RESET_OUT);
    arm = 1'b1; tick();
    check("clr_over_arm", f_st(), 2'd0);
    clr = 1'b0; arm = 1'b0; tick();
    exp_q.delete();

    // Asynchronous reset mid-capture
    do_arm();
    for (int i = 0; i < 5; i++) step_probe(32'(i + 1));
    check("ar_cap", f_st(), 2'd2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out", la_out, RESET_OUT);
    #3 rst_n = 1'b1;
    tick();
    check("ar_idle", la_out, RESET_OUT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
